// File: rtl/logic16_serial_unit.sv
// Slice-serial AND/OR/XOR/NAND engine: one SLICE-bit slice per cycle, LSB slice first.
// out_valid rises N cycles after acceptance; a held result blocks new operations until out_ready.
module logic16_serial_unit #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             any
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("logic16_serial_unit: SLICE must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic [1:0]       op_cap;
  logic [CW-1:0]    cnt;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] sres;
  logic [WIDTH-1:0] out_nx;
  logic             last;

  assign last = (cnt == LAST);

  // Slice k of the captured operands combined and merged into the current result.
  always_comb begin
    sa     = a_cap[cnt*SLICE +: SLICE];
    sb     = b_cap[cnt*SLICE +: SLICE];
    sres   = '0;
    case (op_cap)
      2'b00:   sres = sa & sb;
      2'b01:   sres = sa | sb;
      2'b10:   sres = sa ^ sb;
      default: sres = ~(sa & sb);
    endcase
    out_nx = out;
    out_nx[cnt*SLICE +: SLICE] = sres;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_cap  <= '0;
      b_cap  <= '0;
      op_cap <= '0;
      cnt    <= '0;
      out    <= '0;
      any    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_cap  <= a;
            b_cap  <= b;
            op_cap <= op;
            cnt    <= '0;
            out    <= '0;
            any    <= 1'b0;
          end
        end
        RUN: begin
          out <= out_nx;
          // Counter parks on the last slice rather than wrapping.
          if (last) any <= |out_nx;
          else      cnt <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
